dot_seq_accum: RTL and testbench

DOT_SEQ_ACCUM -- requirements
Module: dot_seq_accum

---
 rtl/dot_seq_accum_if.sv | 31 +++
 rtl/dot_seq_accum.sv | 123 ++++++++++++
 tb/tb_dot_seq_accum.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_accum_if.sv
// Element stream, dot-unit lanes and result handshake for dot_seq_accum.
interface dot_seq_accum_if #(
    parameter int SIZEA = 8,
    parameter int SIZEB = 8,
    parameter int DOT   = 5,
    parameter int ACCW  = 32,
    parameter int LENW  = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [SIZEA-1:0]       in_a;
    logic signed [SIZEB-1:0]       in_b;
    logic                          in_last;
    logic signed [SIZEA-1:0]       dot_a [0:DOT-1];
    logic signed [SIZEB-1:0]       dot_b [0:DOT-1];
    logic signed [SIZEA+SIZEB+1:0] dot_res;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACCW-1:0]        out_sum;
    logic [LENW-1:0]               out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last, dot_res, out_ready,
        output in_ready, dot_a, dot_b, out_valid, out_sum, out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_last, dot_res, out_ready,
        input  in_ready, dot_a, dot_b, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/dot_seq_accum.sv
// Streams signed element pairs into DOT-wide groups for an external sum-of-products
// unit and accumulates the returned lane sums into one dot product per vector.
//   state | meaning
//   FILL  | accepting elements, issuing groups
//   DRAIN | last group issued, waiting for its result
//   DONE  | result held on out_sum/out_count until out_ready
module dot_seq_accum #(
    parameter int SIZEA = 8,
    parameter int SIZEB = 8,
    parameter int DOT   = 5,
    parameter int LAT   = 4,
    parameter int ACCW  = 32,
    parameter int LENW  = 16
) (
    input logic             clk,
    input logic             rst,
    dot_seq_accum_if.slave  bus
);
    localparam int RW = SIZEA + SIZEB + 2;
    localparam int LW = (DOT > 1) ? $clog2(DOT) : 1;

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    state_t                  state;
    logic [LW-1:0]           lane;
    logic signed [SIZEA-1:0] stage_a [0:DOT-1];
    logic signed [SIZEB-1:0] stage_b [0:DOT-1];
    logic [LAT:0]            tag_valid;
    logic [LAT:0]            tag_last;
    logic signed [ACCW-1:0]  acc;
    logic [LENW-1:0]         cnt;

    logic                    accept;
    logic                    issue;
    logic signed [ACCW-1:0]  res_ext;

    assign accept  = bus.in_valid && bus.in_ready;
    assign issue   = accept && (bus.in_last || lane == LW'(DOT - 1));
    assign res_ext = {{(ACCW - RW){bus.dot_res[RW-1]}}, bus.dot_res};

    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;

    // tag bit 0 rides with the dot register update; bit LAT lines up with dot_res
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            lane          <= '0;
            cnt           <= '0;
            acc           <= '0;
            tag_valid     <= '0;
            tag_last      <= '0;
            for (int k = 0; k < DOT; k++) begin
                bus.dot_a[k] <= '0;
                bus.dot_b[k] <= '0;
                stage_a[k]   <= '0;
                stage_b[k]   <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], issue};
            tag_last  <= {tag_last[LAT-1:0], issue && bus.in_last};

            for (int k = 0; k < DOT; k++) begin
                bus.dot_a[k] <= '0;
                bus.dot_b[k] <= '0;
            end

            if (accept) begin
                cnt <= cnt + 1'b1;
                if (issue) begin
                    lane <= '0;
                    for (int k = 0; k < DOT; k++) begin
                        if (LW'(k) < lane) begin
                            bus.dot_a[k] <= stage_a[k];
                            bus.dot_b[k] <= stage_b[k];
                        end else if (LW'(k) == lane) begin
                            bus.dot_a[k] <= bus.in_a;
                            bus.dot_b[k] <= bus.in_b;
                        end
                    end
                end else begin
                    stage_a[lane] <= bus.in_a;
                    stage_b[lane] <= bus.in_b;
                    lane          <= lane + 1'b1;
                end
            end

            if (tag_valid[LAT]) begin
                acc <= acc + res_ext;
            end

            case (state)
                FILL: begin
                    if (accept && bus.in_last) begin
                        state        <= DRAIN;
                        bus.in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (tag_valid[LAT] && tag_last[LAT]) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= FILL;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                        lane          <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_seq_accum.sv
// Directed bench for dot_seq_accum: vector table plus hold and mid-flight reset
// sequences, with a LAT-cycle behavioural sum-of-products unit on the dot lanes.
module tb_dot_seq_accum;
    localparam int SA   = 8;
    localparam int SB   = 8;
    localparam int DOT  = 5;
    localparam int LAT  = 4;
    localparam int ACCW = 32;
    localparam int LENW = 16;
    localparam int RW   = SA + SB + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_seq_accum_if #(.SIZEA(SA), .SIZEB(SB), .DOT(DOT), .ACCW(ACCW), .LENW(LENW)) ifc ();

    dot_seq_accum #(
        .SIZEA(SA), .SIZEB(SB), .DOT(DOT), .LAT(LAT), .ACCW(ACCW), .LENW(LENW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    // behavioural unit: registered lanes in, lane sum out LAT edges later; never reset
    logic signed [RW-1:0] pipe [0:LAT-1];

    function automatic int lane_sum();
        int s = 0;
        for (int k = 0; k < DOT; k++) s += int'(ifc.dot_a[k]) * int'(ifc.dot_b[k]);
        return s;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= RW'(lane_sum());
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ifc.dot_res = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        string name;
        int    n;
        int    a0;
        int    step;
        int    b;
        int    exp_sum;
        int    exp_cnt;
        bit    hold;
    } vec_t;

    vec_t vecs[6];
    int   cap_a [DOT];
    int   cap_b [DOT];

    task automatic send_vec(input vec_t v, output int t_last);
        int guard;
        t_last = -1;
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_a     = SA'(v.a0 + v.step * i);
            ifc.in_b     = SB'(v.b);
            ifc.in_last  = (i == v.n - 1);
            guard = 0;
            while (!ifc.in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk({v.name, "_in_ready_timeout"}, 0, 1);
            if (i == v.n - 1) t_last = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        for (int k = 0; k < DOT; k++) begin
            cap_a[k] = int'(ifc.dot_a[k]);
            cap_b[k] = int'(ifc.dot_b[k]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t_last, t_valid, guard, bad, base, idx, ea, eb;
        longint s0, c0;
        send_vec(v, t_last);

        bad  = 0;
        base = ((v.n - 1) / DOT) * DOT;
        for (int k = 0; k < DOT; k++) begin
            idx = base + k;
            ea  = (idx < v.n) ? v.a0 + v.step * idx : 0;
            eb  = (idx < v.n) ? v.b : 0;
            if (cap_a[k] != ea || cap_b[k] != eb) bad++;
        end
        chk({v.name, "_last_group_lanes_bad"}, bad, 0);

        guard = 0;
        while (!ifc.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        t_valid = cyc;
        chk({v.name, "_out_valid_latency"}, ifc.out_valid ? t_valid - t_last : -1, LAT + 2);
        chk({v.name, "_out_sum"}, ifc.out_sum, v.exp_sum);
        chk({v.name, "_out_count"}, ifc.out_count, v.exp_cnt);

        if (v.hold) begin
            s0  = ifc.out_sum;
            c0  = ifc.out_count;
            bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (!ifc.out_valid || ifc.out_sum != s0 || ifc.out_count != c0 || ifc.in_ready) bad++;
            end
            chk({v.name, "_hold_unstable_cycles"}, bad, 0);
        end

        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.out_ready = 1'b0;
        chk({v.name, "_post_handshake_fill"}, {ifc.in_ready, ifc.out_valid}, 2'b10);
    endtask

    initial begin
        vec_t r5;
        int   t_dummy;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;

        vecs[0] = '{"ramp5",  5,    1, 1,    1,     15,  5, 1'b1};
        vecs[1] = '{"neg7",   7, -128, 0, -128, 114688,  7, 1'b0};
        vecs[2] = '{"single", 1, -128, 0,  127, -16256,  1, 1'b0};
        vecs[3] = '{"twos3",  3,    2, 0,    2,     12,  3, 1'b0};
        vecs[4] = '{"twos6",  6,    2, 0,    2,     24,  6, 1'b0};
        vecs[5] = '{"ramp10", 10,  -3, 1,    3,     45, 10, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", ifc.in_ready, 1);
        chk("reset_out_valid", ifc.out_valid, 0);
        chk("reset_out_sum", ifc.out_sum, 0);
        chk("reset_out_count", ifc.out_count, 0);
        chk("reset_dot_a0", ifc.dot_a[0], 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // two groups in flight (issued on elements 5 and 6), then reset
        r5 = '{"inflight", 6, 1, 0, 1, 6, 6, 1'b0};
        send_vec(r5, t_dummy);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", ifc.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_late_accum_sum", ifc.out_sum, 0);
        chk("rst_no_late_out_valid", ifc.out_valid, 0);
        chk("rst_fill_in_ready", ifc.in_ready, 1);

        r5 = '{"after_rst_ramp5", 5, 1, 1, 1, 15, 5, 1'b0};
        run_vec(r5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
